// File: rtl/ie_sequencer.sv
// Instruction-execution sequencer: walks one decoded instruction through memory read, ALU, memory write and stack beats.
// Latency: start->done 1 (nop), 2 (ALU/branch), 3 (load/store/push/pull), 4 (jsr/rts), 5 (rti/break) with mem_ready high.
// Backpressure: every memory beat holds its request until mem_ready; start is only taken while ready=1.
module ie_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       is_load,
    input  logic       is_store,
    input  logic       is_branch,
    input  logic       is_jsr,
    input  logic       is_rts,
    input  logic       is_rti,
    input  logic       is_break,
    input  logic       is_stack_op,
    input  logic       is_nop,
    input  logic       stack_pull,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       ready,
    output logic       mem_rd_en,
    output logic       mem_wr_en,
    output logic       stack_push,
    output logic       stack_pop,
    output logic       alu_en,
    output logic       pc_load,
    output logic       done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MEM_RD = 3'd1,
        EXEC   = 3'd2,
        MEM_WR = 3'd3,
        STACK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;        // remaining stack beats
    logic       push_q, push_d;      // stack direction: 1=push, 0=pop
    logic       store_q, store_d;
    logic       branch_q, branch_d;
    logic       reload_q, reload_d;  // jsr/rts/rti/break always reload the PC
    logic       taken_q, taken_d;    // branch outcome captured in EXEC

    logic ready_q, ready_d;
    logic rd_q, rd_d;
    logic wr_q, wr_d;
    logic push_o_q, push_o_d;
    logic pop_o_q, pop_o_d;
    logic alu_q, alu_d;
    logic pc_q, pc_d;
    logic done_q, done_d;

    // Next-state, instruction latch and registered-output decode.
    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        push_d   = push_q;
        store_d  = store_q;
        branch_d = branch_q;
        reload_d = reload_q;
        taken_d  = taken_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    store_d  = is_store;
                    branch_d = is_branch;
                    reload_d = is_jsr | is_rts | is_rti | is_break;
                    taken_d  = 1'b0;
                    // Stack beat count and direction follow the same precedence.
                    if (is_break) begin
                        cnt_d = 2'd3; push_d = 1'b1;
                    end else if (is_rti) begin
                        cnt_d = 2'd3; push_d = 1'b0;
                    end else if (is_rts) begin
                        cnt_d = 2'd2; push_d = 1'b0;
                    end else if (is_jsr) begin
                        cnt_d = 2'd2; push_d = 1'b1;
                    end else if (is_stack_op) begin
                        cnt_d = 2'd1; push_d = ~stack_pull;
                    end else begin
                        cnt_d = 2'd0; push_d = 1'b0;
                    end
                    if (is_nop)       state_d = DONE;
                    else if (is_load) state_d = MEM_RD;
                    else              state_d = EXEC;
                end
            end
            MEM_RD: begin
                if (mem_ready) state_d = EXEC;
            end
            EXEC: begin
                taken_d = branch_q & branch_taken;
                if (store_q)            state_d = MEM_WR;
                else if (cnt_q != 2'd0) state_d = STACK;
                else                    state_d = DONE;
            end
            MEM_WR: begin
                if (mem_ready) state_d = (cnt_q != 2'd0) ? STACK : DONE;
            end
            STACK: begin
                if (mem_ready) begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d  = (state_d == IDLE);
        rd_d     = (state_d == MEM_RD) || ((state_d == STACK) && !push_d);
        wr_d     = (state_d == MEM_WR) || ((state_d == STACK) && push_d);
        push_o_d = (state_d == STACK) && push_d;
        pop_o_d  = (state_d == STACK) && !push_d;
        alu_d    = (state_d == EXEC);
        done_d   = (state_d == DONE);
        pc_d     = (state_d == DONE) && (reload_d || taken_d);
    end

    // State, latched instruction attributes and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            push_q   <= 1'b0;
            store_q  <= 1'b0;
            branch_q <= 1'b0;
            reload_q <= 1'b0;
            taken_q  <= 1'b0;
            ready_q  <= 1'b1;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            push_o_q <= 1'b0;
            pop_o_q  <= 1'b0;
            alu_q    <= 1'b0;
            pc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            push_q   <= push_d;
            store_q  <= store_d;
            branch_q <= branch_d;
            reload_q <= reload_d;
            taken_q  <= taken_d;
            ready_q  <= ready_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            push_o_q <= push_o_d;
            pop_o_q  <= pop_o_d;
            alu_q    <= alu_d;
            pc_q     <= pc_d;
            done_q   <= done_d;
        end
    end

    assign ready      = ready_q;
    assign mem_rd_en  = rd_q;
    assign mem_wr_en  = wr_q;
    assign stack_push = push_o_q;
    assign stack_pop  = pop_o_q;
    assign alu_en     = alu_q;
    assign pc_load    = pc_q;
    assign done       = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_ie_sequencer.sv
// Bench for ie_sequencer: directed latency/boundary steps followed by random instructions.
// Reference model expands each accepted instruction into a list of beats and consumes them cycle by cycle.
// Memory beats stay at the head of the list until mem_ready is seen.
module tb_ie_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start, is_load, is_store, is_branch, is_jsr, is_rts, is_rti;
    logic       is_break, is_stack_op, is_nop, stack_pull, branch_taken, mem_ready;
    logic       ready, mem_rd_en, mem_wr_en, stack_push, stack_pop, alu_en, pc_load, done;
    logic [2:0] state;

    always #5 clk = ~clk;

    ie_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .is_jsr(is_jsr), .is_rts(is_rts), .is_rti(is_rti), .is_break(is_break),
        .is_stack_op(is_stack_op), .is_nop(is_nop), .stack_pull(stack_pull),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .ready(ready), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .stack_push(stack_push), .stack_pop(stack_pop), .alu_en(alu_en),
        .pc_load(pc_load), .done(done), .state(state)
    );

    localparam int B_RD = 1, B_ALU = 2, B_WR = 3, B_PUSH = 4, B_POP = 5, B_DONE = 6;
    localparam logic [10:0] IDLE_VEC = 11'h400;

    int   checks = 0;
    int   errors = 0;
    int   q[$];
    logic pc_exp = 1'b0;
    logic br_lat = 1'b0;
    int   rd_seen = 0, done_seen = 0, ready_start_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {ready, rd, wr, push, pop, alu, pc_load, done, state}
    function automatic logic [10:0] observed();
        return {ready, mem_rd_en, mem_wr_en, stack_push, stack_pop, alu_en, pc_load, done, state};
    endfunction

    function automatic logic [10:0] expected();
        logic [10:0] e;
        int b;
        e = '0;
        b = (q.size() == 0) ? 0 : q[0];
        case (b)
            B_RD:   begin e[9] = 1'b1; e[2:0] = 3'd1; end
            B_ALU:  begin e[5] = 1'b1; e[2:0] = 3'd2; end
            B_WR:   begin e[8] = 1'b1; e[2:0] = 3'd3; end
            B_PUSH: begin e[8] = 1'b1; e[7] = 1'b1; e[2:0] = 3'd4; end
            B_POP:  begin e[9] = 1'b1; e[6] = 1'b1; e[2:0] = 3'd4; end
            B_DONE: begin e[3] = 1'b1; e[4] = pc_exp; e[2:0] = 3'd5; end
            default: e[10] = 1'b1;
        endcase
        return e;
    endfunction

    // Turn the instruction on the inputs into its beat list.
    task automatic build();
        int  n;
        logic psh;
        q.delete();
        pc_exp = is_jsr | is_rts | is_rti | is_break;
        br_lat = is_branch;
        if (is_nop) begin
            q.push_back(B_DONE);
        end else begin
            if (is_load) q.push_back(B_RD);
            q.push_back(B_ALU);
            if (is_store) q.push_back(B_WR);
            if (is_break)         begin n = 3; psh = 1'b1; end
            else if (is_rti)      begin n = 3; psh = 1'b0; end
            else if (is_rts)      begin n = 2; psh = 1'b0; end
            else if (is_jsr)      begin n = 2; psh = 1'b1; end
            else if (is_stack_op) begin n = 1; psh = ~stack_pull; end
            else                  begin n = 0; psh = 1'b0; end
            for (int i = 0; i < n; i++) q.push_back(psh ? B_PUSH : B_POP);
            q.push_back(B_DONE);
        end
    endtask

    // One clock: compare at the falling edge, advance the model with the inputs the DUT will sample.
    task automatic cycle();
        @(negedge clk);
        check("outputs", 32'(observed()), 32'(expected()));
        check("rd_wr_exclusive", 32'(mem_rd_en & mem_wr_en), 32'd0);
        if (mem_rd_en) rd_seen++;
        if (done) done_seen++;
        if (ready && start) ready_start_seen++;
        if (q.size() == 0) begin
            if (start) build();
        end else if (q[0] == B_RD || q[0] == B_WR || q[0] == B_PUSH || q[0] == B_POP) begin
            if (mem_ready) void'(q.pop_front());
        end else begin
            if (q[0] == B_ALU) pc_exp = pc_exp | (br_lat & branch_taken);
            void'(q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    // 0 nop, 1 plain ALU, 2 load, 3 store, 4 branch, 5 jsr, 6 rts, 7 rti, 8 break, 9 push, 10 pull
    task automatic set_instr(input int kind);
        {is_load, is_store, is_branch, is_jsr, is_rts, is_rti, is_break, is_stack_op, is_nop} = '0;
        stack_pull = 1'b0;
        case (kind)
            0:  is_nop = 1'b1;
            2:  is_load = 1'b1;
            3:  is_store = 1'b1;
            4:  is_branch = 1'b1;
            5:  is_jsr = 1'b1;
            6:  is_rts = 1'b1;
            7:  is_rti = 1'b1;
            8:  is_break = 1'b1;
            9:  is_stack_op = 1'b1;
            10: begin is_stack_op = 1'b1; stack_pull = 1'b1; end
            default: ;
        endcase
    endtask

    // Issue one instruction with mem_ready high and measure start->done latency.
    task automatic run_lat(input string tag, input int kind, input int exp_lat, input logic exp_pc);
        int lat;
        set_instr(kind);
        mem_ready = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 12) begin
            cycle();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_pc_load"}, 32'(pc_load), 32'(exp_pc));
        cycle();
        check({tag, "_ready_after"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int r0, d0, s0;
        start = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
        set_instr(1);

        // Reset state, including start held high while in reset.
        #2 reset_n = 1'b0;
        #1 check("reset_outputs", 32'(observed()), 32'(IDLE_VEC));
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_hold_start", 32'(observed()), 32'(IDLE_VEC));
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency table with mem_ready tied high.
        run_lat("nop",   0, 1, 1'b0);
        run_lat("alu",   1, 2, 1'b0);
        run_lat("load",  2, 3, 1'b0);
        run_lat("store", 3, 3, 1'b0);
        run_lat("jsr",   5, 4, 1'b1);
        run_lat("rts",   6, 4, 1'b1);
        run_lat("rti",   7, 5, 1'b1);
        run_lat("brk",   8, 5, 1'b1);
        run_lat("push",  9, 3, 1'b0);
        run_lat("pull", 10, 3, 1'b0);
        branch_taken = 1'b0;
        run_lat("br_not_taken", 4, 2, 1'b0);
        branch_taken = 1'b1;
        run_lat("br_taken", 4, 2, 1'b1);
        branch_taken = 1'b0;

        // Load with three stalled cycles before the acknowledge.
        set_instr(2);
        mem_ready = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        r0 = rd_seen;
        repeat (3) cycle();
        mem_ready = 1'b1;
        cycle();
        check("load_alu_after_ack", 32'(alu_en), 32'd1);
        cycle();
        check("load_done_after_alu", 32'(done), 32'd1);
        cycle();
        check("load_rd_cycles", 32'(rd_seen - r0), 32'd4);

        // Start held high across back-to-back stores: one accept per ready window.
        set_instr(3);
        mem_ready = 1'b1;
        start = 1'b1;
        d0 = done_seen;
        s0 = ready_start_seen;
        repeat (12) cycle();
        start = 1'b0;
        check("held_start_dones", 32'(done_seen - d0), 32'd3);
        check("held_start_windows", 32'(ready_start_seen - s0), 32'd3);
        repeat (2) cycle();

        // Reset asserted during the second pop beat of rti.
        set_instr(7);
        mem_ready = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        check("rti_second_pop", 32'(stack_pop), 32'd1);
        #2 reset_n = 1'b0;
        #1 check("reset_mid_stack", 32'(observed()), 32'(IDLE_VEC));
        q.delete();
        pc_exp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_lat("jsr_after_reset", 5, 4, 1'b1);

        // Random instructions, flag mixes, stalls and branch outcomes.
        for (int i = 0; i < 600; i++) begin
            set_instr(int'($urandom_range(0, 10)));
            if ($urandom_range(0, 7) == 0) is_store = 1'b1;
            if ($urandom_range(0, 7) == 0) is_load = 1'b1;
            if ($urandom_range(0, 7) == 0) is_branch = 1'b1;
            if (!is_stack_op) stack_pull = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 9) < 6);
            branch_taken = 1'($urandom_range(0, 1));
            cycle();
        end
        start = 1'b0;
        mem_ready = 1'b1;
        repeat (8) cycle();
        check("final_idle", 32'(ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
